// File: rtl/char_spike_gen.sv
// Character stimulus generator: a writable table of pixel patterns driven onto
// NUM_PIX lines from a programmable square-wave carrier, in differential or spike mode.
module char_spike_gen #(
    parameter int NUM_PIX   = 16,
    parameter int NUM_CHARS = 4,
    parameter int DIV_W     = 32,
    localparam int CSEL_W   = $clog2(NUM_CHARS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                mode,
    input  logic [CSEL_W-1:0]   char_sel,
    input  logic [DIV_W-1:0]    clk_div,
    input  logic [15:0]         burst_len,
    input  logic                wr_en,
    input  logic [CSEL_W-1:0]   wr_addr,
    input  logic [NUM_PIX-1:0]  wr_data,
    output logic [NUM_PIX-1:0]  pix_out,
    output logic                pix_clk,
    output logic                busy,
    output logic                done,
    output logic [15:0]         period_cnt
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_n;
    logic [NUM_PIX-1:0]  tbl [NUM_CHARS];
    logic [DIV_W-1:0]    div_cnt, div_cnt_n, div_lat, div_lat_n;
    logic [15:0]         burst_lat, burst_lat_n, period_cnt_n, pc_inc;
    logic [NUM_PIX-1:0]  pat, pat_n, sel_pat, pix_n;
    logic                phase_n, done_n, spike_n, wrap, burst_end, launch;

    function automatic logic [NUM_PIX-1:0] rst_entry(input int unsigned idx);
        rst_entry = '0;
        if (NUM_PIX == 16) begin
            case (idx)
                0:       rst_entry = NUM_PIX'(16'h9F8F);
                1:       rst_entry = NUM_PIX'(16'h6998);
                2:       rst_entry = NUM_PIX'(16'h9DA9);
                3:       rst_entry = NUM_PIX'(16'h96F9);
                default: rst_entry = '0;
            endcase
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CHARS; i++)
                tbl[CSEL_W'(i)] <= rst_entry(i);
        end else if (wr_en && (32'(wr_addr) < 32'(NUM_CHARS))) begin
            tbl[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        sel_pat = '0;
        if (32'(char_sel) < 32'(NUM_CHARS))
            sel_pat = tbl[char_sel];
    end

    assign launch    = start && !stop;
    assign wrap      = (div_cnt == div_lat);
    assign pc_inc    = (period_cnt == '1) ? period_cnt : period_cnt + 16'd1;
    // A period boundary is the wrap at the end of the low half (carrier 0->1).
    assign burst_end = (state == RUN) && wrap && !pix_clk &&
                       (burst_lat != '0) && (pc_inc == burst_lat);
    assign busy      = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (launch) state_n = RUN;
            RUN:     if (stop || burst_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        div_cnt_n    = div_cnt;
        div_lat_n    = div_lat;
        burst_lat_n  = burst_lat;
        period_cnt_n = period_cnt;
        pat_n        = pat;
        phase_n      = 1'b0;
        done_n       = 1'b0;
        spike_n      = 1'b0;
        case (state)
            IDLE: begin
                if (launch) begin
                    div_lat_n    = clk_div;
                    burst_lat_n  = burst_len;
                    period_cnt_n = '0;
                    div_cnt_n    = '0;
                    pat_n        = sel_pat;
                    phase_n      = 1'b1;
                    spike_n      = 1'b1;
                end
            end
            RUN: begin
                if (!stop) begin
                    if (!wrap) begin
                        div_cnt_n = div_cnt + 1'b1;
                        phase_n   = pix_clk;
                    end else begin
                        div_cnt_n = '0;
                        if (!pix_clk) begin
                            period_cnt_n = pc_inc;
                            if (burst_end) begin
                                done_n = 1'b1;
                            end else begin
                                pat_n   = sel_pat;
                                phase_n = 1'b1;
                                spike_n = 1'b1;
                            end
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        pix_n = '0;
        if (state_n == RUN) begin
            if (mode) pix_n = spike_n ? pat_n : '0;
            else      pix_n = phase_n ? pat_n : ~pat_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            div_lat    <= '0;
            burst_lat  <= '0;
            period_cnt <= '0;
            pat        <= '0;
            pix_clk    <= 1'b0;
            pix_out    <= '0;
            done       <= 1'b0;
        end else begin
            div_cnt    <= div_cnt_n;
            div_lat    <= div_lat_n;
            burst_lat  <= burst_lat_n;
            period_cnt <= period_cnt_n;
            pat        <= pat_n;
            pix_clk    <= phase_n;
            pix_out    <= pix_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_char_spike_gen.sv
// Bench for char_spike_gen: directed scenarios plus randomized runs against a
// period/phase arithmetic model of the expected waveform.
module tb_char_spike_gen;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, mode, wr_en;
    logic [1:0]  char_sel, wr_addr;
    logic [31:0] clk_div;
    logic [15:0] burst_len, wr_data;
    logic [15:0] pix_out, period_cnt, pix_out2, period_cnt2;
    logic        pix_clk, busy, done, pix_clk2, busy2, done2;
    logic [34:0] dut_vec, dut2_vec;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    char_spike_gen #(.NUM_PIX(16), .NUM_CHARS(4), .DIV_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .char_sel(char_sel), .clk_div(clk_div), .burst_len(burst_len),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pix_out(pix_out), .pix_clk(pix_clk), .busy(busy), .done(done),
        .period_cnt(period_cnt)
    );

    char_spike_gen #(.NUM_PIX(16), .NUM_CHARS(3), .DIV_W(32)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .char_sel(char_sel), .clk_div(clk_div), .burst_len(burst_len),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pix_out(pix_out2), .pix_clk(pix_clk2), .busy(busy2), .done(done2),
        .period_cnt(period_cnt2)
    );

    assign dut_vec  = {busy, done, pix_clk, period_cnt, pix_out};
    assign dut2_vec = {busy2, done2, pix_clk2, period_cnt2, pix_out2};

    // Reference: a run is a count k of cycles since start; the carrier phase and
    // spike position follow from k modulo the full period 2*(clk_div+1).
    logic [15:0] tbl_m [4];
    bit          m_run, m_done, m_mode;
    longint      m_k, m_half;
    logic [15:0] m_blen, m_pc, m_pat;

    function automatic void model_reset();
        tbl_m[0] = 16'h9F8F; tbl_m[1] = 16'h6998;
        tbl_m[2] = 16'h9DA9; tbl_m[3] = 16'h96F9;
        m_run = 0; m_done = 0; m_mode = 0; m_k = 0; m_half = 1;
        m_blen = 0; m_pc = 0; m_pat = 0;
    endfunction

    function automatic void model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_done = 0;
        if (!m_run) begin
            if (start && !stop) begin
                m_run = 1; m_k = 0; m_half = longint'(clk_div) + 1;
                m_blen = burst_len; m_pc = 0; m_pat = tbl_m[char_sel];
            end
        end else if (stop) begin
            m_run = 0;
        end else begin
            m_k++;
            if (m_k % (2 * m_half) == 0) begin
                if (m_pc != 16'hFFFF) m_pc++;
                if (m_blen != 0 && m_pc == m_blen) begin
                    m_run = 0; m_done = 1;
                end else begin
                    m_pat = tbl_m[char_sel];
                end
            end
        end
        if (wr_en) tbl_m[wr_addr] = wr_data;
        m_mode = mode;
    endfunction

    function automatic logic [34:0] exp_vec();
        longint pos;
        logic pclk;
        logic [15:0] pix;
        if (!m_run) return {1'b0, m_done, 1'b0, m_pc, 16'h0000};
        pos  = m_k % (2 * m_half);
        pclk = (pos < m_half);
        if (m_mode) pix = (pos == 0) ? m_pat : 16'h0000;
        else        pix = pclk ? m_pat : ~m_pat;
        return {1'b1, 1'b0, pclk, m_pc, pix};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; start = 0; stop = 0; mode = 0; wr_en = 0;
        char_sel = 0; wr_addr = 0; clk_div = 0; burst_len = 0; wr_data = 0;
        #3;
        model_reset();
        n_cmp++;
        if (dut_vec !== 35'h0) begin
            n_bad++; $display("FAIL reset_async got %h want %h", dut_vec, 35'h0);
        end
        tick();
        rst_n = 1;
        tick();
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL reset_idle got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_diff();
        int ndone = 0;
        mode = 0; char_sel = 0; clk_div = 1; burst_len = 2; start = 1;
        tick();
        start = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            if (done) ndone++;
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL diff cyc%0d got %h want %h", c, dut_vec, exp_vec());
            end
            if (c == 2) begin
                n_cmp++;
                if (pix_out !== 16'h6070) begin
                    n_bad++; $display("FAIL diff_low_half got %h want 6070", pix_out);
                end
            end
        end
        n_cmp++;
        if (ndone !== 1 || period_cnt !== 16'd2) begin
            n_bad++; $display("FAIL diff_burst_end done_pulses %0d pc %0d want 1 2", ndone, period_cnt);
        end
    endtask

    task automatic test_spike();
        mode = 1; char_sel = 3; clk_div = 3; burst_len = 0; start = 1;
        tick();
        start = 0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL spike cyc%0d got %h want %h", c, dut_vec, exp_vec());
            end
        end
        stop = 1;
        tick();
        stop = 0;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL spike_stop cyc%0d got %h want %h", c, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_midwrite();
        mode = 0; char_sel = 1; clk_div = 1; burst_len = 0; start = 1;
        tick();
        start = 0;
        wr_en = 1; wr_addr = 1; wr_data = 16'hFFFF;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            if (c == 1) wr_en = 0;
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL midwrite cyc%0d got %h want %h", c, dut_vec, exp_vec());
            end
        end
        stop = 1;
        tick();
        stop = 0;
        tick();
    endtask

    task automatic test_div0();
        int done_at = -1;
        mode = 0; char_sel = 2; clk_div = 0; burst_len = 1; start = 1;
        tick();
        start = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            if (done) done_at = c;
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL div0 cyc%0d got %h want %h", c, dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if (done_at !== 2) begin
            n_bad++; $display("FAIL div0_done_cycle got %0d want 2", done_at);
        end
    endtask

    task automatic test_start_stop();
        mode = 0; char_sel = 0; clk_div = 0; burst_len = 0; start = 1; stop = 1;
        tick();
        start = 0; stop = 0;
        n_cmp++;
        if (busy !== 1'b0 || dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL start_stop_same got %h want %h", dut_vec, exp_vec());
        end
        start = 1;
        tick();
        start = 0;
        for (int c = 0; c < 6; c++) tick();
        start = 1; clk_div = 5;
        tick();
        start = 0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            n_cmp++;
            if (dut_vec !== exp_vec() || period_cnt === 16'd0) begin
                n_bad++; $display("FAIL start_while_busy cyc%0d got %h want %h", c, dut_vec, exp_vec());
            end
        end
        stop = 1;
        tick();
        stop = 0;
        tick();
    endtask

    task automatic test_sel_oob();
        mode = 0; char_sel = 3; clk_div = 1; burst_len = 0; start = 1;
        tick();
        start = 0;
        n_cmp++;
        if (dut2_vec !== {1'b1, 1'b0, 1'b1, 16'd0, 16'h0000}) begin
            n_bad++; $display("FAIL oob_sel_high got %h want %h", dut2_vec, {3'b101, 32'h0});
        end
        tick(); tick();
        n_cmp++;
        if (dut2_vec !== {1'b1, 1'b0, 1'b0, 16'd0, 16'hFFFF}) begin
            n_bad++; $display("FAIL oob_sel_low got %h want %h", dut2_vec, {3'b100, 16'd0, 16'hFFFF});
        end
        char_sel = 2;
        tick(); tick();
        n_cmp++;
        if (dut2_vec !== {1'b1, 1'b0, 1'b1, 16'd1, 16'h9DA9}) begin
            n_bad++; $display("FAIL oob_sel_valid got %h want %h", dut2_vec, {3'b101, 16'd1, 16'h9DA9});
        end
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL oob_main got %h want %h", dut_vec, exp_vec());
        end
        stop = 1;
        tick();
        stop = 0;
        tick();
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            mode = 1'($urandom % 2); char_sel = 2'($urandom % 4);
            clk_div = $urandom % 4; burst_len = 16'($urandom % 5); start = 1;
            tick();
            start = 0;
            for (int c = 0; c < 40; c++) begin
                n_cmp++;
                if (dut_vec !== exp_vec()) begin
                    n_bad++; $display("FAIL random run%0d cyc%0d got %h want %h", r, c, dut_vec, exp_vec());
                end
                mode     = 1'($urandom % 2);
                char_sel = 2'($urandom % 4);
                wr_en    = ($urandom % 8 == 0);
                wr_addr  = 2'($urandom % 4);
                wr_data  = 16'($urandom);
                stop     = ($urandom % 40 == 0);
                start    = ($urandom % 12 == 0);
                tick();
            end
            wr_en = 0; start = 0; stop = 1;
            tick();
            stop = 0;
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL random_end run%0d got %h want %h", r, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_reset_midrun();
        mode = 0; char_sel = 0; clk_div = 1; burst_len = 0; start = 1;
        tick();
        start = 0;
        tick(); tick();
        #2 rst_n = 0;
        #1 model_reset();
        n_cmp++;
        if (dut_vec !== exp_vec() || busy !== 1'b0 || pix_out !== 16'h0) begin
            n_bad++; $display("FAIL reset_midrun got %h want %h", dut_vec, exp_vec());
        end
        tick();
        rst_n = 1;
        char_sel = 1; start = 1;
        tick();
        start = 0;
        n_cmp++;
        if (pix_out !== 16'h6998 || dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL table_restored got %h want 6998", pix_out);
        end
        stop = 1;
        tick();
        stop = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_diff();
        test_spike();
        test_midwrite();
        test_div0();
        test_start_stop();
        test_sel_oob();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
